// File: rtl/lfsr_prbs_checker.sv
// Far-end checker for the 8-bit Galois PRBS generator: self-syncs, flags and counts errors.
// Define PRBS_CHK_BIT_ERR_EN to count mismatched bits instead of mismatched words.
module lfsr_prbs_checker #(
   parameter logic [1:8] TAP_COEFFICIENT = 8'b1100_1111,
   parameter int         LOCK_COUNT      = 4,
   parameter int         LOSS_COUNT      = 4,
   parameter int         ERR_CNT_W       = 16
) (
   input  logic                 Clock,
   input  logic                 Reset,
   input  logic [1:8]           Data,
   input  logic                 Data_Valid,
   input  logic                 Clear,
   output logic                 Locked,
   output logic                 Error,
   output logic [ERR_CNT_W-1:0] Err_Count,
   output logic [1:0]           State
);

   typedef enum logic [1:0] {
      HUNT   = 2'd0,
      CHECK  = 2'd1,
      LOCKED = 2'd2,
      BAD    = 2'd3
   } state_t;

   localparam logic [3:0] LOCK_N = 4'(LOCK_COUNT);
   localparam logic [3:0] LOSS_N = 4'(LOSS_COUNT);
   // Feedback mask for positions 2..8 (tap index mirrors position)
   localparam logic [2:8] FB = {
      TAP_COEFFICIENT[7], TAP_COEFFICIENT[6],
      TAP_COEFFICIENT[5], TAP_COEFFICIENT[4],
      TAP_COEFFICIENT[3], TAP_COEFFICIENT[2],
      TAP_COEFFICIENT[1]
   };

   function automatic logic [1:8] nxt(input logic [1:8] w);
      logic [1:8] r;
      r[1]   = w[8];
      r[2:8] = w[1:7] ^ (FB & {7{w[8]}});
      return r;
   endfunction

   state_t               state_q, state_d;
   logic [1:8]           pred_q, pred_d;
   logic [3:0]           match_q, match_d;
   logic [3:0]           miss_q, miss_d;
   logic                 error_q, error_d;
   logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
   logic [ERR_CNT_W:0]   sum;
   logic [3:0]           inc;
   logic [3:0]           match_inc;
   logic [3:0]           miss_inc;
   logic                 bump;

`ifdef PRBS_CHK_BIT_ERR_EN
   logic [1:8] diff;
   assign diff = Data ^ pred_q;
   assign inc  = {3'b0, diff[1]} + {3'b0, diff[2]}
               + {3'b0, diff[3]} + {3'b0, diff[4]}
               + {3'b0, diff[5]} + {3'b0, diff[6]}
               + {3'b0, diff[7]} + {3'b0, diff[8]};
`else
   assign inc = 4'd1;
`endif

   assign match_inc = match_q + 4'd1;
   assign miss_inc  = miss_q + 4'd1;
   assign sum       = {1'b0, cnt_q} + (ERR_CNT_W+1)'(inc);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q <= HUNT;
         pred_q  <= '0;
         match_q <= '0;
         miss_q  <= '0;
         error_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pred_q  <= pred_d;
         match_q <= match_d;
         miss_q  <= miss_d;
         error_q <= error_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pred_d  = pred_q;
      match_d = match_q;
      miss_d  = miss_q;
      error_d = 1'b0;
      bump    = 1'b0;
      if (state_q == BAD) begin
         state_d = HUNT;
      end else if (Data_Valid) begin
         unique case (state_q)
            HUNT: begin
               if (Data != '0) begin
                  pred_d  = nxt(Data);
                  match_d = '0;
                  state_d = CHECK;
               end
            end
            CHECK: begin
               if (Data == pred_q) begin
                  pred_d  = nxt(Data);
                  match_d = match_inc;
                  if (match_inc == LOCK_N) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  pred_d  = nxt(Data);
                  match_d = '0;
                  if (Data == '0) state_d = HUNT;
               end
            end
            LOCKED: begin
               if (Data == pred_q) begin
                  pred_d = nxt(Data);
                  miss_d = '0;
               end else begin
                  // Flywheel: ignore the bad word, keep predicting
                  pred_d  = nxt(pred_q);
                  error_d = 1'b1;
                  bump    = 1'b1;
                  miss_d  = miss_inc;
                  if (miss_inc == LOSS_N) begin
                     state_d = HUNT;
                     miss_d  = '0;
                  end
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (Clear)
         cnt_d = '0;
      else if (bump)
         cnt_d = sum[ERR_CNT_W] ? '1 : sum[ERR_CNT_W-1:0];
   end

   assign Locked    = (state_q == LOCKED);
   assign Error     = error_q;
   assign Err_Count = cnt_q;
   assign State     = state_q;

endmodule

// File: tb/tb_lfsr_prbs_checker.sv
// Directed bench for lfsr_prbs_checker: acquisition, errors, loss, gaps,
// saturation, clear and async reset.
module tb_lfsr_prbs_checker;

   localparam int CW = 8;

   logic          Clock = 1'b0;
   logic          Reset;
   logic [1:8]    Data;
   logic          Data_Valid;
   logic          Clear;
   logic          Locked;
   logic          Error;
   logic [CW-1:0] Err_Count;
   logic [1:0]    State;

   int checks = 0;
   int errors = 0;
   int exp_cnt = 0;
   int nval;
   logic [7:0] gen;
   logic [0:7] gp;

   lfsr_prbs_checker #(.ERR_CNT_W(CW)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .Data(Data),
      .Data_Valid(Data_Valid),
      .Clear(Clear),
      .Locked(Locked),
      .Error(Error),
      .Err_Count(Err_Count),
      .State(State)
   );

   always #5 Clock = ~Clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   // Generator step: rotate right, XOR 73h when the shifted-out bit is 1
   function automatic logic [7:0] f(input logic [7:0] w);
      return {w[0], w[7:1]} ^ (w[0] ? 8'h73 : 8'h00);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [7:0] d, input logic v,
                       input logic c);
      @(negedge Clock);
      Data       = d;
      Data_Valid = v;
      Clear      = c;
      @(posedge Clock);
      #1;
      Data_Valid = 1'b0;
      Clear      = 1'b0;
   endtask

   task automatic good();
      step(gen, 1'b1, 1'b0);
      gen = f(gen);
   endtask

   task automatic bad(input logic [7:0] m, input logic c);
      step(gen ^ m, 1'b1, c);
      gen = f(gen);
   endtask

   task automatic bump_exp(input int n);
      exp_cnt = exp_cnt + n;
      if (exp_cnt > 255) exp_cnt = 255;
   endtask

   initial begin
      Reset = 1'b1;
      Data = '0;
      Data_Valid = 1'b0;
      Clear = 1'b0;
      repeat (2) @(posedge Clock);
      #1;
      chk("rst_state", 32'(State), 0);
      chk("rst_locked", 32'(Locked), 0);
      chk("rst_error", 32'(Error), 0);
      chk("rst_cnt", 32'(Err_Count), 0);
      @(negedge Clock);
      Reset = 1'b0;

      // acquisition on 91h, BBh, ...
      gen = 8'h91;
      for (int k = 1; k <= 5; k++) begin
         good();
         chk("acq_state", 32'(State), (k < 5) ? 1 : 2);
         chk("acq_locked", 32'(Locked), (k == 5) ? 1 : 0);
      end
      for (int k = 0; k < 95; k++) begin
         good();
         chk("run_error", 32'(Error), 0);
      end
      chk("run_cnt", 32'(Err_Count), 0);
      chk("run_locked", 32'(Locked), 1);

      // single bit-1 corruption
      bad(8'h80, 1'b0);
      bump_exp(1);
      chk("one_error", 32'(Error), 1);
      chk("one_cnt", 32'(Err_Count), exp_cnt);
      chk("one_locked", 32'(Locked), 1);
      good();
      chk("one_next_err", 32'(Error), 0);
      chk("one_next_state", 32'(State), 2);
      chk("one_next_cnt", 32'(Err_Count), exp_cnt);
      good();
      good();

      // three flipped bits
      bad(8'hE0, 1'b0);
`ifdef PRBS_CHK_BIT_ERR_EN
      bump_exp(3);
`else
      bump_exp(1);
`endif
      chk("tri_cnt", 32'(Err_Count), exp_cnt);
      good();
      chk("tri_next_err", 32'(Error), 0);

      // loss of lock
      for (int k = 1; k <= 4; k++) begin
         bad(8'h80, 1'b0);
         bump_exp(1);
         chk("loss_error", 32'(Error), 1);
         chk("loss_locked", 32'(Locked), (k < 4) ? 1 : 0);
         chk("loss_cnt", 32'(Err_Count), exp_cnt);
      end
      chk("loss_state", 32'(State), 0);
      for (int k = 1; k <= 5; k++) begin
         good();
         chk("relock", 32'(Locked), (k == 5) ? 1 : 0);
         chk("relock_cnt", 32'(Err_Count), exp_cnt);
      end

      // saturation
      for (int g = 0; g < 90; g++) begin
         for (int j = 0; j < 3; j++) begin
            bad(8'h80, 1'b0);
            bump_exp(1);
         end
         good();
      end
      chk("sat_cnt", 32'(Err_Count), 32'hFF);
      chk("sat_locked", 32'(Locked), 1);
      bad(8'h80, 1'b0);
      chk("sat_hold", 32'(Err_Count), 32'hFF);
      chk("sat_error", 32'(Error), 1);
      good();

      // clear together with an error
      bad(8'h80, 1'b1);
      exp_cnt = 0;
      chk("clr_error", 32'(Error), 1);
      chk("clr_cnt", 32'(Err_Count), 0);
      bad(8'h80, 1'b0);
      bump_exp(1);
      chk("clr_after", 32'(Err_Count), exp_cnt);

      // async reset between edges
      #2;
      Reset = 1'b1;
      #1;
      chk("arst_state", 32'(State), 0);
      chk("arst_locked", 32'(Locked), 0);
      chk("arst_error", 32'(Error), 0);
      chk("arst_cnt", 32'(Err_Count), 0);
      @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         good();
         chk("reacq", 32'(Locked), (k == 5) ? 1 : 0);
      end

      // lockup word in HUNT
      @(negedge Clock);
      Reset = 1'b1;
      @(negedge Clock);
      Reset = 1'b0;
      step(8'h00, 1'b1, 1'b0);
      chk("zero_hunt", 32'(State), 0);
      step(8'h00, 1'b1, 1'b0);
      chk("zero_hunt2", 32'(State), 0);
      good();
      chk("zero_seed", 32'(State), 1);

      // gaps: only valid words advance acquisition
      nval = 1;
      gp = 8'b0100_1101;
      for (int i = 0; i < 8; i++) begin
         if (gp[i]) begin
            good();
            nval++;
         end else begin
            step(8'($urandom), 1'b0, 1'b0);
         end
         chk("gap_locked", 32'(Locked), (nval >= 5) ? 1 : 0);
         chk("gap_error", 32'(Error), 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lfsr_prbs_checker.md
Name: lfsr_prbs_checker

Overview:
- Downstream consumer of the 8-bit internal-XOR (Galois) LFSR generator.
- Receives the generator's parallel state word each valid cycle and self-synchronises to it.
- Predicts each next word, flags mismatches and counts errors.
- Used for link/datapath BIST: the generator drives the path under test, and this block sits at the far end.

Parameters:
- TAP_COEFFICIENT, 8'b1100_1111, feedback taps indexed [1:8]; must equal the generator's setting.
- LOCK_COUNT, 4, consecutive matching words after the seed word required to declare lock (1..15).
- LOSS_COUNT, 4, consecutive mismatching words in LOCKED that drop lock (1..15).
- ERR_CNT_W, 16, width of the error counter.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Data  input  [1:8]  received generator word; bit 1 is leftmost/MSB, same numbering as the generator.
- Data_Valid  input  1  Data is sampled only when high.
- Clear  input  1  synchronous clear of Err_Count only.
- Locked  output  1  high while in LOCKED.
- Error  output  1  one-cycle pulse per mismatched word while LOCKED.
- Err_Count  output  ERR_CNT_W  saturating error count.
- State  output  2  HUNT=0, CHECK=1, LOCKED=2 (3 unused; if reached, go to HUNT).

Behaviour:
- Next-state function f(W), identical to the generator:
  - f[1] = W[8].
  - for i = 2..8: f[i] = W[i-1] ^ (TAP_COEFFICIENT[9-i] & W[8]).
  - Reference value: f(91h) = BBh.
- Reset (async, Reset=1):
  - State=HUNT, Locked=0, Error=0, Err_Count=0.
  - Internal Pred=00h, match_cnt=0, miss_cnt=0.
  - Reset mid-stream aborts everything immediately; resync restarts from HUNT.
- Data_Valid=0: no state, counter or Pred change; Error forced 0 on the next edge.
- HUNT:
  - Valid nonzero Data: Pred<=f(Data), match_cnt<=0, go CHECK.
  - Data=00h (lockup word) is ignored; stay HUNT.
- CHECK:
  - Valid, Data==Pred: Pred<=f(Data), match_cnt++.
  - When match_cnt reaches LOCK_COUNT: go LOCKED, Locked=1 on that same edge.
  - Valid, Data!=Pred: reseed. Pred<=f(Data), match_cnt<=0, stay CHECK; if Data=00h, go HUNT instead.
  - No errors are counted in CHECK.
- LOCKED:
  - Valid, Data==Pred: Pred<=f(Data), miss_cnt<=0.
  - Valid, Data!=Pred (flywheel):
    - Pred<=f(Pred); the received word is discarded.
    - Error<=1 for one cycle; Err_Count increments, saturating at all-ones.
    - miss_cnt++; when miss_cnt reaches LOSS_COUNT: go HUNT, Locked<=0, miss_cnt<=0.
  - The word that triggers loss of lock is still counted and pulses Error.
- Lock latency: the seed word plus LOCK_COUNT matching words. With the default 4, Locked rises on the edge that samples the 5th valid word.
- All outputs are registered: Error and Err_Count update on the edge that samples the offending word.
- Clear:
  - Err_Count<=0 on the edge.
  - Clear takes priority over an increment in the same cycle; the increment is lost.
  - Error still pulses.
- Err_Count holds its value across loss of lock and relock. Only Reset or Clear zero it.

Optional Feature:
- Macro PRBS_CHK_BIT_ERR_EN.
- Defined: Err_Count increments by popcount(Data ^ Pred) (1..8) per mismatched LOCKED word, saturating at all-ones; no wrap on overflow.
- Undefined: increments by 1 per mismatched word.
- Error pulse, state machine and ports are identical in both builds.

Test Plan:
- Acquire lock: reset, then feed the generator stream 91h, BBh, ... continuously valid.
  - State goes HUNT->CHECK after 91h.
  - Locked=1 after the 5th word; Err_Count=0 for 100 words.
- Single corruption while locked: flip bit 1 of one word.
  - Exactly one Error pulse; Err_Count=1.
  - Next correct word matches, with no resync.
  - With PRBS_CHK_BIT_ERR_EN, flip 3 bits -> Err_Count=3.
- Loss of lock: while locked, drive 4 consecutive wrong words.
  - 4 Error pulses; Err_Count=4.
  - Locked falls on the 4th; State=HUNT.
  - Relocks 5 words later; Err_Count stays 4.
- Gaps and lockup word:
  - Toggle Data_Valid randomly during acquisition -> lock timing counts only valid words.
  - Feed 00h in HUNT -> stays HUNT.
- Saturation and Clear:
  - Force errors past 2^ERR_CNT_W-1 -> Err_Count holds FFFFh.
  - Assert Clear together with an error -> Err_Count=0 and Error=1.
- Async reset mid-lock: assert Reset between clock edges.
  - All outputs 0 immediately.
  - After release, full reacquisition is required.
